// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame constants and data-shifter state encoding
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOADED, XFER, DONE} spi_state_t;
    localparam int SPI_DATA_W   = 8;
    localparam int SPI_WAIT_MAX = 15;
endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: registered-history edge detector with enable gating
module spi_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    input  logic i_en,
    output logic o_rise,
    output logic o_fall
);
    logic r_d;
    // history resets high because the SPI clock idles high
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_d <= 1'b1;
        else         r_d <= i_sig;
    assign o_rise = i_sig & ~r_d & i_en;
    assign o_fall = ~i_sig & r_d & i_en;
endmodule

// File: rtl/spi_data_shifter.sv
// spi_data_shifter: mode-3 MSB-first serialiser/deserialiser beside the SPI clock generator
module spi_data_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int WAIT_MAX = SPI_WAIT_MAX
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tx_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_spi_ss,
    input  logic              i_spi_clk,
    input  logic              i_spi_busy,
    input  logic              i_spi_miso,
    output logic              o_spi_mosi,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_error
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);
    spi_state_t        state;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     wait_cnt;
    logic              spi_rise, spi_fall;
    spi_edge_detect u_edge (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_sig  (i_spi_clk),
        .i_en   (~i_spi_ss),
        .o_rise (spi_rise),
        .o_fall (spi_fall)
    );
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state      <= IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            o_spi_mosi <= 1'b1;
            o_tx_ready <= 1'b1;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            o_error    <= 1'b0;
            case (state)
                IDLE: if (i_tx_start) begin
                    tx_sr      <= i_tx_data;
                    o_spi_mosi <= i_tx_data[DATA_W-1];
                    bit_cnt    <= '0;
                    wait_cnt   <= '0;
                    o_tx_ready <= 1'b0;
                    state      <= LOADED;
                end
                LOADED: if (!i_spi_ss) state <= XFER;
                else begin
                    if (wait_cnt != WW'(WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt >= WW'(WAIT_MAX - 1)) begin
                        o_error    <= 1'b1;
                        o_spi_mosi <= 1'b1;
                        o_tx_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                XFER: if (i_spi_ss || (spi_fall && bit_cnt == BW'(DATA_W))) begin
                    o_error    <= 1'b1;
                    o_spi_mosi <= 1'b1;
                    o_tx_ready <= 1'b1;
                    state      <= IDLE;
                end else if (spi_rise) begin
                    rx_sr   <= {rx_sr[DATA_W-2:0], i_spi_miso};
                    tx_sr   <= tx_sr << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    // last rise publishes the word directly so valid lands one cycle later
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        o_rx_data  <= {rx_sr[DATA_W-2:0], i_spi_miso};
                        o_rx_valid <= 1'b1;
                        o_spi_mosi <= 1'b1;
                        state      <= DONE;
                    end else o_spi_mosi <= tx_sr[DATA_W-2];
                end
                DONE: if (!i_spi_busy && i_spi_ss) begin
                    o_tx_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi_data_shifter.sv
// tb_spi_data_shifter: generator model plus scoreboard bench for spi_data_shifter
module tb_spi_data_shifter;
    localparam int DW = 8;
    localparam int WM = 15;
    logic          i_clk = 1'b0;
    logic          i_reset, i_tx_start, i_spi_ss, i_spi_clk, i_spi_busy, i_spi_miso;
    logic [DW-1:0] i_tx_data;
    logic          o_spi_mosi, o_tx_ready, o_rx_valid, o_error;
    logic [DW-1:0] o_rx_data;
    logic [DW-1:0] exp_q[$];
    int            total = 0, bad = 0, n_valid = 0, n_err = 0;
    spi_data_shifter #(.DATA_W(DW), .WAIT_MAX(WM)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_tx_start(i_tx_start),
        .i_tx_data (i_tx_data),
        .i_spi_ss  (i_spi_ss),
        .i_spi_clk (i_spi_clk),
        .i_spi_busy(i_spi_busy),
        .i_spi_miso(i_spi_miso),
        .o_spi_mosi(o_spi_mosi),
        .o_tx_ready(o_tx_ready),
        .o_rx_data (o_rx_data),
        .o_rx_valid(o_rx_valid),
        .o_error   (o_error)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge i_clk);
    endtask
    always @(negedge i_clk) begin
        if (o_error) n_err++;
        if (o_rx_valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("rx_extra", 32'(exp_q.size()), 1);
            else check("rx_data", 32'(o_rx_data), 32'(exp_q.pop_front()));
        end
    end
    // generator model: ss low 3 cycles after start, 2-low/2-high SPI clock, stop early by abort or reset
    task automatic frame(input logic [DW-1:0] tx, input bit loopback, input logic [DW-1:0] miso_w,
                         input int stop_at, input bit rst_mode, input int poke_at);
        if (stop_at == DW) exp_q.push_back(loopback ? tx : miso_w);
        i_tx_data  = tx;
        i_tx_start = 1'b1;
        i_spi_busy = 1'b1;
        tick();
        i_tx_start = 1'b0;
        i_tx_data  = DW'($urandom);
        check("ready_low", 32'(o_tx_ready), 0);
        tick();
        tick();
        i_spi_ss = 1'b0;
        tick();
        for (int b = 0; b < stop_at; b++) begin
            if (b == poke_at) begin
                i_tx_start = 1'b1;
                i_tx_data  = '0;
            end
            i_spi_clk = 1'b0;
            tick();
            i_tx_start = 1'b0;
            tick();
            check("mosi_bit", 32'(o_spi_mosi), 32'((tx >> (DW - 1 - b)) & 1));
            i_spi_miso = loopback ? o_spi_mosi : miso_w[DW-1-b];
            i_spi_clk  = 1'b1;
            tick();
            tick();
        end
        if (rst_mode) begin
            #3 i_reset = 1'b1;
            #1;
            check("rst_mosi", 32'(o_spi_mosi), 1);
            check("rst_ready", 32'(o_tx_ready), 1);
            check("rst_rx", 32'(o_rx_data), 0);
            check("rst_valid", 32'(o_rx_valid), 0);
            i_spi_ss   = 1'b1;
            i_spi_busy = 1'b0;
            tick();
            i_reset = 1'b0;
        end else begin
            i_spi_ss   = 1'b1;
            i_spi_busy = 1'b0;
        end
        tick();
        tick();
        tick();
    endtask
    initial begin
        int n;
        i_reset = 1'b1; i_tx_start = 1'b0; i_tx_data = '0; i_spi_ss = 1'b1;
        i_spi_clk = 1'b1; i_spi_busy = 1'b0; i_spi_miso = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        check("reset_mosi", 32'(o_spi_mosi), 1);
        check("reset_ready", 32'(o_tx_ready), 1);
        check("reset_rx", 32'(o_rx_data), 0);
        check("reset_valid", 32'(o_rx_valid), 0);
        check("reset_err", 32'(o_error), 0);
        frame(8'hA5, 1'b1, 8'h00, DW, 1'b0, -1);
        check("loop_rx", 32'(o_rx_data), 32'h A5);
        check("loop_ready", 32'(o_tx_ready), 1);
        check("loop_nvalid", 32'(n_valid), 1);
        frame(8'hFF, 1'b0, 8'h3C, DW, 1'b0, -1);
        check("indep_rx", 32'(o_rx_data), 32'h3C);
        frame(8'h81, 1'b1, 8'h00, DW, 1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("poke_idle", 32'(o_tx_ready), 1);
        end
        check("poke_rx", 32'(o_rx_data), 32'h81);
        check("poke_nvalid", 32'(n_valid), 3);
        frame(8'h5A, 1'b1, 8'h00, 5, 1'b0, -1);
        check("abort_err", 32'(n_err), 1);
        check("abort_rx", 32'(o_rx_data), 32'h81);
        check("abort_ready", 32'(o_tx_ready), 1);
        check("abort_mosi", 32'(o_spi_mosi), 1);
        i_tx_data  = 8'h77;
        i_tx_start = 1'b1;
        tick();
        i_tx_start = 1'b0;
        check("to_ready_low", 32'(o_tx_ready), 0);
        n = 1;
        while (!o_error && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 32'(n), 32'(WM + 1));
        check("to_ready", 32'(o_tx_ready), 1);
        check("to_mosi", 32'(o_spi_mosi), 1);
        tick();
        check("to_err_cnt", 32'(n_err), 2);
        frame(8'hC3, 1'b1, 8'h00, 3, 1'b1, -1);
        for (int i = 0; i < 10; i++) tick();
        check("rst_nvalid", 32'(n_valid), 3);
        check("rst_nerr", 32'(n_err), 2);
        check("rst_rx_after", 32'(o_rx_data), 0);
        check("rst_ready_after", 32'(o_tx_ready), 1);
        check("q_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
